nibble_operand_serializer: RTL and testbench

- Upstream feeder for the 2x4b bit-serial adder.
- Accepts 8-bit operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Issues each pair to the adder as two nibble beats: low nibbles, then high nibbles.
- Beats are kept in lock-step with the adder's free-running 2-cycle phase, so a low nibble always lands on adder phase 0 (carry cleared) and a high nibble on phase 1 (carry propagated).

---
 rtl/nibble_operand_serializer.sv | 105 ++++++++++
 tb/tb_nibble_operand_serializer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/nibble_operand_serializer.sv
// Buffers 8-bit operand pairs and issues them as low/high nibble beats locked to
// the 2x4b adder phase. Optional macro: SERIALIZER_FULL_BYPASS_EN (push while popping when full).
module nibble_operand_serializer #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic       out_val,
  output logic       out_hi,
  output logic       phase
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          phase_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic          push;
  logic          pop;
  logic          full;

  assign full  = (count == FULL_COUNT);
  assign pop   = (state == HI);
  assign push  = in_val && in_rdy;
  assign phase = phase_q;

  // in_rdy is held low for as long as reset is asserted, independent of the registers
`ifdef SERIALIZER_FULL_BYPASS_EN
  assign in_rdy = reset && (!full || (state == HI));
`else
  assign in_rdy = reset && !full;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= 1'b0;
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      phase_q <= ~phase_q;
      state   <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_comb begin
    state_next = state;
    out0       = 4'h0;
    out1       = 4'h0;
    out_val    = 1'b0;
    out_hi     = 1'b0;
    case (state)
      IDLE: begin
        if (!phase_q && (count != '0)) begin
          out0       = mem_a[rd_ptr][3:0];
          out1       = mem_b[rd_ptr][3:0];
          out_val    = 1'b1;
          state_next = HI;
        end
      end
      HI: begin
        out0       = mem_a[rd_ptr][7:4];
        out1       = mem_b[rd_ptr][7:4];
        out_val    = 1'b1;
        out_hi     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibble_operand_serializer.sv
// Randomized bench for nibble_operand_serializer, checked every cycle against a
// queue-based model of pair acceptance and nibble scheduling.
module tb_nibble_operand_serializer;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_val = 1'b0;
  logic       in_rdy;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [3:0] out0;
  logic [3:0] out1;
  logic       out_val;
  logic       out_hi;
  logic       phase;

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         modelHi    = 1'b0;
  bit         modelPhase = 1'b0;

  nibble_operand_serializer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .in_val (in_val),
    .in_rdy (in_rdy),
    .in_a   (in_a),
    .in_b   (in_b),
    .out0   (out0),
    .out1   (out1),
    .out_val(out_val),
    .out_hi (out_hi),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observed();
    return {20'd0, out_val, out_hi, phase, in_rdy, out0, out1};
  endfunction

  function automatic bit modelReady();
    bit bypass = 1'b0;
`ifdef SERIALIZER_FULL_BYPASS_EN
    bypass = 1'b1;
`endif
    return (qa.size() != DEPTH) || (bypass && modelHi);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s cycle %0d: observed {val,hi,phase,rdy,o0,o1}=0x%03h, expected 0x%03h",
                  tag, cycle, obs[11:0], exp[11:0]);
  endtask

  // Reset is asserted with inputs idle; outputs must collapse at once, not at the next edge.
  task automatic doReset(input string tag);
    in_val = 1'b0;
    reset  = 1'b0;
    #1;
    checkOutput({tag, "_async"}, observed(), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_hold"}, observed(), 32'd0);
    reset = 1'b1;
    qa.delete();
    qb.delete();
    modelHi    = 1'b0;
    modelPhase = 1'b0;
  endtask

  // One clock cycle: drive, compare at negedge against the model, then advance the model.
  task automatic applyStimulus(input string tag, input bit valid, input logic [7:0] a,
                               input logic [7:0] b, output bit accepted);
    logic [3:0] e0, e1;
    bit ev, eh, er, startLow;
    in_val = valid;
    in_a   = a;
    in_b   = b;
    @(negedge clk);
    er = modelReady();
    e0 = 4'h0; e1 = 4'h0; ev = 1'b0; eh = 1'b0; startLow = 1'b0;
    if (modelHi) begin
      e0 = qa[0][7:4]; e1 = qb[0][7:4]; ev = 1'b1; eh = 1'b1;
    end else if (!modelPhase && qa.size() > 0) begin
      e0 = qa[0][3:0]; e1 = qb[0][3:0]; ev = 1'b1; startLow = 1'b1;
    end
    checkOutput(tag, observed(), {20'd0, ev, eh, modelPhase, er, e0, e1});
    if (modelHi) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    accepted = valid && er;
    if (accepted) begin
      qa.push_back(a);
      qb.push_back(b);
    end
    modelHi    = startLow;
    modelPhase = ~modelPhase;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    bit acc;
    int guard;
    logic [7:0] ra, rb;

    doReset("reset");
    for (int i = 0; i < 6; i++) applyStimulus("idle_after_reset", 1'b0, 8'h00, 8'h00, acc);

    // 0x3C + 0x29 accepted just before a phase-0 cycle
    if (!modelPhase) applyStimulus("align", 1'b0, 8'h00, 8'h00, acc);
    applyStimulus("push_3c29", 1'b1, 8'h3C, 8'h29, acc);
    for (int i = 0; i < 4; i++) applyStimulus("issue_3c29", 1'b0, 8'h00, 8'h00, acc);

    // 0xFF + 0x01 accepted into a phase-1 cycle: one idle beat first
    if (modelPhase) applyStimulus("align", 1'b0, 8'h00, 8'h00, acc);
    applyStimulus("push_ff01", 1'b1, 8'hFF, 8'h01, acc);
    for (int i = 0; i < 5; i++) applyStimulus("issue_ff01", 1'b0, 8'h00, 8'h00, acc);

    // Three back-to-back pairs: the third has to wait for room
    for (int p = 0; p < 3; p++) begin
      ra = 8'(8'h11 * (p + 1));
      rb = 8'(8'h0F + p);
      acc = 1'b0;
      for (guard = 0; guard < 12 && !acc; guard++) applyStimulus("b2b_push", 1'b1, ra, rb, acc);
      if (!acc) checkOutput("b2b_accept_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 8; i++) applyStimulus("b2b_drain", 1'b0, 8'h00, 8'h00, acc);

    // Reset pulsed during a high beat drops the pair
    applyStimulus("mid_push", 1'b1, 8'hA5, 8'h5A, acc);
    for (guard = 0; guard < 6 && !modelHi; guard++) applyStimulus("mid_wait", 1'b0, 8'h00, 8'h00, acc);
    if (!modelHi) checkOutput("mid_hi_timeout", 32'd0, 32'd1);
    doReset("mid_reset");
    for (int i = 0; i < 4; i++) applyStimulus("after_mid_reset", 1'b0, 8'h00, 8'h00, acc);

    // Saturating supply keeps the FIFO full
    for (int i = 0; i < 24; i++)
      applyStimulus("full_hold", 1'b1, 8'($urandom), 8'($urandom), acc);
    for (int i = 0; i < 8; i++) applyStimulus("full_drain", 1'b0, 8'h00, 8'h00, acc);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) doReset("rand_reset");
      applyStimulus("random", ($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom), acc);
    end
    for (int i = 0; i < 8; i++) applyStimulus("final_drain", 1'b0, 8'h00, 8'h00, acc);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
